alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu.sv | 93 +++++++++
 tb/tb_alu.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered single-cycle ALU, one operation per clock, result carries carry/borrow in bit WIDTH.
// Optional zero/ovf flag outputs are built only when ALU_FLAGS_EN is defined.
module alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic [WIDTH:0]   out,
  output logic             out_valid
`ifdef ALU_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_SLTU = 3'b111;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] res;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Select the next result; diff[WIDTH] is the borrow, reused for SLTU
  always_comb begin
    res = '0;
    unique case (sel)
      OP_PASS: res = {1'b0, a};
      OP_ADD:  res = sum;
      OP_SUB:  res = diff;
      OP_AND:  res = {1'b0, a & b};
      OP_OR:   res = {1'b0, a | b};
      OP_XOR:  res = {1'b0, a ^ b};
      OP_NOT:  res = {1'b0, ~a};
      OP_SLTU: res = {{WIDTH{1'b0}}, diff[WIDTH]};
      default: res = '0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic ovf_n;
  logic zero_n;

  // Signed overflow only exists for ADD and SUB
  always_comb begin
    ovf_n  = 1'b0;
    zero_n = (res[WIDTH-1:0] == '0);
    if (sel == OP_ADD)
      ovf_n = (a[WIDTH-1] == b[WIDTH-1]) &&
              (sum[WIDTH-1] != a[WIDTH-1]);
    else if (sel == OP_SUB)
      ovf_n = (a[WIDTH-1] != b[WIDTH-1]) &&
              (diff[WIDTH-1] != a[WIDTH-1]);
  end

  // Flags update together with out and hold when idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero <= 1'b0;
      ovf  <= 1'b0;
    end else if (in_valid) begin
      zero <= zero_n;
      ovf  <= ovf_n;
    end
  end
`endif

  // Result register: reset wins, idle cycles hold out and drop out_valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid)
        out <= res;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu at WIDTH=8.
// Flag checks are compiled in when ALU_FLAGS_EN is defined.
module tb_alu;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   sel;
  logic [W:0]   out;
  logic         out_valid;
`ifdef ALU_FLAGS_EN
  logic         zero;
  logic         ovf;
`endif

  int passed = 0;
  int total  = 0;

  alu #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .a(a),
    .b(b),
    .sel(sel),
    .out(out),
    .out_valid(out_valid)
`ifdef ALU_FLAGS_EN
    ,
    .zero(zero),
    .ovf(ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] exp;
    logic       ez;
    logic       eo;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic v, input logic r, input logic [2:0] s,
                       input logic [7:0] xa, input logic [7:0] xb);
    @(negedge clk);
    rst_n    = r;
    in_valid = v;
    sel      = s;
    a        = xa;
    b        = xb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{"pass",     3'b000, 8'hA5, 8'h00, 9'h0A5, 1'b0, 1'b0};
    tbl[1]  = '{"add10_5",  3'b001, 8'd10, 8'd5,  9'h00F, 1'b0, 1'b0};
    tbl[2]  = '{"add255_1", 3'b001, 8'hFF, 8'h01, 9'h100, 1'b1, 1'b0};
    tbl[3]  = '{"sub5_10",  3'b010, 8'd5,  8'd10, 9'h1FB, 1'b0, 1'b0};
    tbl[4]  = '{"sub127_255",3'b010,8'h7F, 8'hFF, 9'h180, 1'b0, 1'b1};
    tbl[5]  = '{"add127_1", 3'b001, 8'h7F, 8'h01, 9'h080, 1'b0, 1'b1};
    tbl[6]  = '{"and",      3'b011, 8'hF0, 8'h3C, 9'h030, 1'b0, 1'b0};
    tbl[7]  = '{"or",       3'b100, 8'hF0, 8'h3C, 9'h0FC, 1'b0, 1'b0};
    tbl[8]  = '{"xor",      3'b101, 8'hF0, 8'h3C, 9'h0CC, 1'b0, 1'b0};
    tbl[9]  = '{"not",      3'b110, 8'hF0, 8'h3C, 9'h00F, 1'b0, 1'b0};
    tbl[10] = '{"sltu_ge",  3'b111, 8'hF0, 8'h3C, 9'h000, 1'b1, 1'b0};
    tbl[11] = '{"sltu_lt",  3'b111, 8'd3,  8'd200,9'h001, 1'b0, 1'b0};
    tbl[12] = '{"sub200_3", 3'b010, 8'd200,8'd3,  9'h0C5, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; sel = '0; a = '0; b = '0;
    drive(1'b1, 1'b0, 3'b001, 8'd9, 8'd9);
    drive(1'b0, 1'b0, 3'b000, 8'd0, 8'd0);
    check("reset_out", 32'(out), 32'h0);
    check("reset_valid", 32'(out_valid), 32'h0);
`ifdef ALU_FLAGS_EN
    check("reset_zero", 32'(zero), 32'h0);
    check("reset_ovf", 32'(ovf), 32'h0);
`endif

    // back-to-back table, first op on first edge out of reset
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, 1'b1, tbl[i].sel, tbl[i].a, tbl[i].b);
      check({tbl[i].name, "_out"}, 32'(out), 32'(tbl[i].exp));
      check({tbl[i].name, "_vld"}, 32'(out_valid), 32'h1);
`ifdef ALU_FLAGS_EN
      check({tbl[i].name, "_zero"}, 32'(zero), 32'(tbl[i].ez));
      check({tbl[i].name, "_ovf"}, 32'(ovf), 32'(tbl[i].eo));
`endif
    end

    // idle cycle holds result with garbage on inputs
    drive(1'b0, 1'b1, 3'b001, 8'd1, 8'd1);
    check("hold_out", 32'(out), 32'h0C5);
    check("hold_valid", 32'(out_valid), 32'h0);

    // reset beats a concurrent ADD
    drive(1'b1, 1'b0, 3'b001, 8'd10, 8'd5);
    check("rstpri_out", 32'(out), 32'h0);
    check("rstpri_valid", 32'(out_valid), 32'h0);
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b1, 3'b001, 8'd10, 8'd5);
      check("rst_hold_out", 32'(out), 32'h0);
      check("rst_hold_vld", 32'(out_valid), 32'h0);
    end

    // ADD then XOR back-to-back, then idle
    drive(1'b1, 1'b1, 3'b001, 8'd1, 8'd2);
    check("b2b_add_out", 32'(out), 32'h3);
    check("b2b_add_vld", 32'(out_valid), 32'h1);
    drive(1'b1, 1'b1, 3'b101, 8'd3, 8'd3);
    check("b2b_xor_out", 32'(out), 32'h0);
    check("b2b_xor_vld", 32'(out_valid), 32'h1);
`ifdef ALU_FLAGS_EN
    check("b2b_xor_zero", 32'(zero), 32'h1);
`endif
    drive(1'b0, 1'b1, 3'b000, 8'hAA, 8'h00);
    check("b2b_idle_out", 32'(out), 32'h0);
    check("b2b_idle_vld", 32'(out_valid), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
